sram_word_sequencer: RTL and testbench

- Sits directly downstream of the memory controller's SRAM port. Converts one 32-bit word command (start/cmd/addr/wdata/wstrb) into two 16-bit accesses on the board's external asynchronous 256Kx16 SRAM.
- Reports busy and done back to the controller.
- Owns all SRAM pin timing: setup, strobe width, hold and bus turnaround.

---
 rtl/sram_pkg.sv | 14 +
 rtl/sram_word_sequencer.sv | 106 ++++++++++
 tb/tb_sram_word_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: command codes, FSM state encoding and address width shared with the memory controller.
package sram_pkg;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int HW_AW = 18;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;
endpackage

// File: rtl/sram_word_sequencer.sv
// sram_word_sequencer: splits a 32-bit word command into two timed 16-bit accesses on an async SRAM.
module sram_word_sequencer
  import sram_pkg::*;
#(
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        cmd,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [HW_AW-1:0]  sram_a,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);
  localparam int MAXC = READ_CYCLES > WRITE_CYCLES ? READ_CYCLES : WRITE_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  state_t           r_state, w_state_n;
  logic             r_half, w_half_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic [HW_AW-2:0] r_addr;
  logic [31:0]      r_wdata, r_rdata;
  logic [3:0]       r_wstrb;
  logic             w_last, w_rd, w_wr, w_unused;
  logic [1:0]       w_lanes;

  assign w_unused = ^{addr[31:19], addr[1:0]};
  assign w_last = (r_state == ST_RD       && r_cnt == CW'(READ_CYCLES - 1)) ||
                  (r_state == ST_WR_PULSE && r_cnt == CW'(WRITE_CYCLES - 1));
  assign w_cnt_n = (r_state inside {ST_RD, ST_WR_PULSE}) && !w_last ? r_cnt + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_half  <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_n;
      r_half  <= w_half_n;
      r_cnt   <= w_cnt_n;
      if (r_state == ST_IDLE && start) begin
        r_addr  <= addr[18:2];
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (r_state == ST_RD && w_last)
        r_rdata <= r_half ? {sram_dq_in, r_rdata[15:0]} : {r_rdata[31:16], sram_dq_in};
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_half_n  = r_half;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_n = cmd == CMD_READ ? ST_RD :
                    (cmd == CMD_WRITE && |wstrb) ? ST_WR_SETUP : ST_FINISH;
        // a write with an empty low half starts directly on the high half
        w_half_n  = cmd == CMD_WRITE && !(|wstrb[1:0]);
      end
      ST_RD: if (w_last) begin
        w_state_n = r_half ? ST_FINISH : ST_RD;
        w_half_n  = 1'b1;
      end
      ST_WR_SETUP: w_state_n = ST_WR_PULSE;
      ST_WR_PULSE: if (w_last) w_state_n = ST_WR_HOLD;
      ST_WR_HOLD: begin
        w_state_n = (!r_half && |r_wstrb[3:2]) ? ST_WR_SETUP : ST_FINISH;
        w_half_n  = 1'b1;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd        = r_state == ST_RD;
    w_wr        = r_state inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
    w_lanes     = r_half ? r_wstrb[3:2] : r_wstrb[1:0];
    busy        = r_state != ST_IDLE;
    done        = r_state == ST_FINISH;
    rdata       = r_rdata;
    sram_a      = (w_rd || w_wr) ? {r_addr, r_half} : '0;
    sram_cs_n   = !(w_rd || w_wr);
    sram_oe_n   = !w_rd;
    sram_we_n   = r_state != ST_WR_PULSE;
    sram_dq_oe  = w_wr;
    sram_dq_out = w_wr ? (r_half ? r_wdata[31:16] : r_wdata[15:0]) : '0;
    {sram_ub_n, sram_lb_n} = w_rd ? 2'b00 : w_wr ? ~w_lanes : 2'b11;
  end
endmodule

// File: tb/tb_sram_word_sequencer.sv
// tb_sram_word_sequencer: directed scenarios against a behavioural async SRAM with bus-rule monitoring.
module tb_sram_word_sequencer;
  logic        clk = 0, reset = 1, start = 0;
  logic [7:0]  cmd = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        busy, done, sram_dq_oe, sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [31:0] rdata;
  logic [17:0] sram_a;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic [15:0] mem [0:262143];
  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, cs_cnt = 0, we_cnt = 0, oe_cnt = 0, pulses = 0, viol = 0, run = 0;
  logic [17:0] prev_a, last_a;
  logic [15:0] last_dq;
  logic [1:0]  last_lanes;
  logic        prev_we_low = 0;

  sram_word_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .busy(busy), .done(done), .rdata(rdata), .sram_a(sram_a), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;
  assign sram_dq_in = (!sram_cs_n && !sram_oe_n) ? mem[sram_a] : 16'h0000;

  // SRAM write model and pin-rule monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!sram_cs_n) cs_cnt++;
    if (sram_dq_oe) oe_cnt++;
    if ((!sram_oe_n && sram_dq_oe) || (!sram_we_n && !sram_oe_n) || (!busy && sram_dq_oe)) viol++;
    if (!sram_we_n) begin
      we_cnt++;
      run++;
      if (prev_we_low && sram_a !== prev_a) viol++;
      if (!sram_cs_n) begin
        if (!sram_lb_n) mem[sram_a][7:0] = sram_dq_out[7:0];
        if (!sram_ub_n) mem[sram_a][15:8] = sram_dq_out[15:8];
      end
      last_a = sram_a;
      last_dq = sram_dq_out;
      last_lanes = {sram_ub_n, sram_lb_n};
    end else if (prev_we_low) begin
      pulses++;
      if (!reset && run != 2) viol++;
      run = 0;
    end
    prev_we_low = !sram_we_n;
    prev_a = sram_a;
  end

  task automatic run_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int lat);
    @(negedge clk);
    start = 1; cmd = c; addr = a; wdata = d; wstrb = s;
    @(negedge clk);
    start = 0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      if (done) begin lat = n; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    n_chk++; if ({busy, done, sram_dq_oe} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, done, sram_dq_oe}); end
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_chk++; if (sram_a !== 18'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", sram_a); end
    n_chk++; if (sram_dq_out !== 16'h0) begin n_fail++; $display("FAIL reset_dq got %h want 0", sram_dq_out); end
    n_chk++; if ({sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'h1F) begin n_fail++; $display("FAIL reset_ctl got %b want 11111", {sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_read;
    int lat, d0, c0, w0, o0;
    d0 = done_cnt; c0 = cs_cnt; w0 = we_cnt; o0 = oe_cnt;
    run_cmd(8'h01, 32'h0000_0104, 32'h0, 4'h0, lat);
    n_chk++; if (lat != 5) begin n_fail++; $display("FAIL read_latency got %0d want 5", lat); end
    n_chk++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data got %h want deadbeef", rdata); end
    n_chk++; if (we_cnt - w0 != 0 || oe_cnt - o0 != 0) begin n_fail++; $display("FAIL read_quiet we=%0d dq_oe=%0d want 0 0", we_cnt - w0, oe_cnt - o0); end
    n_chk++; if (cs_cnt - c0 != 4) begin n_fail++; $display("FAIL read_cs_cycles got %0d want 4", cs_cnt - c0); end
    n_chk++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL read_done_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_write_full;
    int lat, p0, w0;
    p0 = pulses; w0 = we_cnt;
    run_cmd(8'h02, 32'h0000_0010, 32'h1234_5678, 4'hF, lat);
    n_chk++; if (lat != 9) begin n_fail++; $display("FAIL wr_full_latency got %0d want 9", lat); end
    n_chk++; if (pulses - p0 != 2 || we_cnt - w0 != 4) begin n_fail++; $display("FAIL wr_full_pulses got %0d/%0d want 2/4", pulses - p0, we_cnt - w0); end
    n_chk++; if (mem[8] !== 16'h5678) begin n_fail++; $display("FAIL wr_full_lo got %h want 5678", mem[8]); end
    n_chk++; if (mem[9] !== 16'h1234) begin n_fail++; $display("FAIL wr_full_hi got %h want 1234", mem[9]); end
    n_chk++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_full_rdata got %h want deadbeef", rdata); end
  endtask

  task automatic test_write_lane;
    int lat, p0;
    p0 = pulses;
    run_cmd(8'h02, 32'h0000_0010, 32'hAA00_0000, 4'b0100, lat);
    n_chk++; if (lat != 5) begin n_fail++; $display("FAIL wr_lane_latency got %0d want 5", lat); end
    n_chk++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL wr_lane_pulses got %0d want 1", pulses - p0); end
    n_chk++; if ({last_a, last_dq, last_lanes} !== {18'h9, 16'hAA00, 2'b10}) begin n_fail++; $display("FAIL wr_lane_bus got a=%h dq=%h ub_lb=%b want 9 aa00 10", last_a, last_dq, last_lanes); end
    n_chk++; if (mem[9] !== 16'h1200 || mem[8] !== 16'h5678) begin n_fail++; $display("FAIL wr_lane_mem got %h %h want 1200 5678", mem[9], mem[8]); end
  endtask

  task automatic test_noop;
    int lat, c0, d0;
    c0 = cs_cnt; d0 = done_cnt;
    run_cmd(8'h02, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, lat);
    n_chk++; if (lat != 1) begin n_fail++; $display("FAIL nostrb_latency got %0d want 1", lat); end
    run_cmd(8'h7F, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, lat);
    n_chk++; if (lat != 1) begin n_fail++; $display("FAIL badcmd_latency got %0d want 1", lat); end
    n_chk++; if (cs_cnt - c0 != 0 || done_cnt - d0 != 2) begin n_fail++; $display("FAIL noop_activity cs=%0d done=%0d want 0 2", cs_cnt - c0, done_cnt - d0); end
    n_chk++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL noop_rdata got %h want deadbeef", rdata); end
  endtask

  task automatic test_back_to_back;
    int lat = -1, d0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1; cmd = 8'h01; addr = 32'h0000_0200;
    @(negedge clk);
    start = 0;
    for (int n = 1; n <= 15; n++) begin
      if (n == 2) begin start = 1; addr = 32'h0000_0104; end
      else start = 0;
      if (done && lat < 0) lat = n;
      @(negedge clk);
    end
    start = 0;
    n_chk++; if (lat != 5) begin n_fail++; $display("FAIL b2b_latency got %0d want 5", lat); end
    n_chk++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL b2b_done_pulses got %0d want 1", done_cnt - d0); end
    n_chk++; if (rdata !== 32'h2222_1111) begin n_fail++; $display("FAIL b2b_rdata got %h want 22221111", rdata); end
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1; cmd = 8'h02; addr = 32'h0000_0040; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    n_chk++; if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL abort_in_pulse we_n got %b want 0", sram_we_n); end
    reset = 1;
    @(negedge clk);
    n_chk++; if ({sram_we_n, sram_cs_n, sram_dq_oe, busy} !== 4'b1100) begin n_fail++; $display("FAIL abort_idle we_n,cs_n,dq_oe,busy got %b want 1100", {sram_we_n, sram_cs_n, sram_dq_oe, busy}); end
    @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);
    n_chk++; if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", done_cnt - d0); end
  endtask

  initial begin
    mem[18'h82] = 16'hBEEF;
    mem[18'h83] = 16'hDEAD;
    mem[18'h100] = 16'h1111;
    mem[18'h101] = 16'h2222;
    test_reset;
    test_read;
    test_write_full;
    test_write_lane;
    test_noop;
    test_back_to_back;
    test_reset_mid;
    n_chk++; if (viol != 0) begin n_fail++; $display("FAIL bus_rules got %0d violations want 0", viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
